ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/kgp_ex_pkg.sv | 57 +++++
 rtl/ex_stage_alu.sv | 58 +++++
 rtl/ex_stage.sv | 177 +++++++++++++++++
 tb/tb_ex_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_ex_pkg.sv
// Shared definitions for the execute stage: FIFO state encoding, flag bit
// positions, branch-condition codes, ALU opcodes and the branch evaluator.
// Latency: n/a (types and constants only). Backpressure: n/a.
package kgp_ex_pkg;

    // Occupancy of the two-entry result FIFO
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } fifo_state_e;

    // Flag vector layout {carry, zero, sign}
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_S = 0;

    // Branch-condition codes
    localparam logic [2:0] BR_NEVER  = 3'b000;
    localparam logic [2:0] BR_ALWAYS = 3'b001;
    localparam logic [2:0] BR_Z      = 3'b010;
    localparam logic [2:0] BR_NZ     = 3'b011;
    localparam logic [2:0] BR_S      = 3'b100;
    localparam logic [2:0] BR_GT     = 3'b101;
    localparam logic [2:0] BR_C      = 3'b110;
    localparam logic [2:0] BR_NC     = 3'b111;

    // ALU opcodes; unused codes produce a zero result
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;
    localparam logic [3:0] ALU_SLT = 4'b1001;

    // Resolve a branch condition against one instruction's ALU flags
    function automatic logic br_eval(input logic [2:0] cond, input logic [2:0] f);
        logic taken;
        taken = 1'b0;
        case (cond)
            BR_NEVER:  taken = 1'b0;
            BR_ALWAYS: taken = 1'b1;
            BR_Z:      taken = f[FLAG_Z];
            BR_NZ:     taken = !f[FLAG_Z];
            BR_S:      taken = f[FLAG_S];
            BR_GT:     taken = !f[FLAG_S] && !f[FLAG_Z];
            BR_C:      taken = f[FLAG_C];
            BR_NC:     taken = !f[FLAG_C];
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU: result and {carry, zero, sign} flags from two operands.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: ip1/ip2 operands, alu_signal opcode, result, flags.
module alu
    import kgp_ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] ip1,
    input  logic [DATA_W-1:0] ip2,
    input  logic [3:0]        alu_signal,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        flags
);

    localparam int SHW = $clog2(DATA_W);

    logic [DATA_W:0]   add_ext;
    logic [DATA_W:0]   sub_ext;
    logic [SHW-1:0]    shamt;
    logic              carry;

    assign add_ext = {1'b0, ip1} + {1'b0, ip2};
    // Subtraction as ip1 + ~ip2 + 1 so carry-out means "no borrow"
    assign sub_ext = {1'b0, ip1} + {1'b0, ~ip2} + {{DATA_W{1'b0}}, 1'b1};
    assign shamt   = ip2[SHW-1:0];

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (alu_signal)
            ALU_ADD: begin
                result = add_ext[DATA_W-1:0];
                carry  = add_ext[DATA_W];
            end
            ALU_SUB: begin
                result = sub_ext[DATA_W-1:0];
                carry  = sub_ext[DATA_W];
            end
            ALU_AND: result = ip1 & ip2;
            ALU_OR:  result = ip1 | ip2;
            ALU_XOR: result = ip1 ^ ip2;
            ALU_SLL: result = ip1 << shamt;
            ALU_SRL: result = ip1 >> shamt;
            ALU_SRA: result = $signed(ip1) >>> shamt;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, $signed(ip1) < $signed(ip2)};
            default: result = '0;
        endcase
    end

    always_comb begin
        flags         = 3'b000;
        flags[FLAG_C] = carry;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_S] = result[DATA_W-1];
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU on input operands, results queued in a 2-entry FIFO.
// Latency: 1 cycle accept-to-out_valid when empty. Backpressure: in_ready
// drops only when both entries are full; in_ready is a pure state decode.
// Ports: in_valid/in_ready + operands in, out_valid/out_ready + result out,
// flags_q architectural flag register.
// Optional: KGP_EX_BRANCH_EN adds br_cond in and out_br_taken out, one
// taken bit stored per FIFO entry.
module ex_stage
    import kgp_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    input  logic [3:0]        alu_signal,
    input  logic [RA_W-1:0]   rd,
    input  logic              flag_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RA_W-1:0]   out_rd,
    output logic [2:0]        out_flags,
`ifdef KGP_EX_BRANCH_EN
    input  logic [2:0]        br_cond,
    output logic              out_br_taken,
`endif
    output logic [2:0]        flags_q
);

    logic [DATA_W-1:0] alu_ip2;
    logic [DATA_W-1:0] alu_res;
    logic [2:0]        alu_flags;

    assign alu_ip2 = use_imm ? imm : rt_val;

    alu #(.DATA_W(DATA_W)) u_alu (
        .ip1        (rs_val),
        .ip2        (alu_ip2),
        .alu_signal (alu_signal),
        .result     (alu_res),
        .flags      (alu_flags)
    );

    fifo_state_e state_q, state_d;
    logic        accept;
    logic        drain;
    logic        load_head;
    logic        load_tail;
    logic        shift_up;

    // Handshake outputs decode the state register only
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Entry 0 is always the head; entry 1 only ever holds the younger item
    always_comb begin
        state_d   = state_q;
        load_head = 1'b0;
        load_tail = 1'b0;
        shift_up  = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    load_head = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    // Head leaves and the new item takes its place, no bubble
                    load_head = 1'b1;
                end else if (accept) begin
                    state_d   = ST_TWO;
                    load_tail = 1'b1;
                end else if (drain) begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_d  = ST_ONE;
                    shift_up = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    logic [DATA_W-1:0] res_q [2];
    logic [RA_W-1:0]   rd_q  [2];
    logic [2:0]        flg_q [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                res_q[i] <= '0;
                rd_q[i]  <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            if (load_head) begin
                res_q[0] <= alu_res;
                rd_q[0]  <= rd;
                flg_q[0] <= alu_flags;
            end else if (shift_up) begin
                res_q[0] <= res_q[1];
                rd_q[0]  <= rd_q[1];
                flg_q[0] <= flg_q[1];
            end
            if (load_tail) begin
                res_q[1] <= alu_res;
                rd_q[1]  <= rd;
                flg_q[1] <= alu_flags;
            end
        end
    end

    assign out_result = res_q[0];
    assign out_rd     = rd_q[0];
    assign out_flags  = flg_q[0];

`ifdef KGP_EX_BRANCH_EN
    logic br_new;
    logic br_q [2];

    assign br_new = br_eval(br_cond, alu_flags);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_q[0] <= 1'b0;
            br_q[1] <= 1'b0;
        end else begin
            if (load_head) begin
                br_q[0] <= br_new;
            end else if (shift_up) begin
                br_q[0] <= br_q[1];
            end
            if (load_tail) begin
                br_q[1] <= br_new;
            end
        end
    end

    assign out_br_taken = br_q[0];
`endif

    // Architectural flags update at the accept edge, regardless of drain
    logic [2:0] flags_d;

    assign flags_d = (accept && flag_we) ? alu_flags : flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: scoreboard of expected results pushed on
// accept, popped on drain, plus directed checks of reset and handshakes.
// Latency: n/a. Backpressure: out_ready driven directed and randomly.
module tb_ex_stage;
    import kgp_ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs_val, rt_val, imm;
    logic        use_imm;
    logic [3:0]  alu_signal;
    logic [4:0]  rd;
    logic        flag_we;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [2:0]  out_flags;
    logic [2:0]  flags_q;
    logic [2:0]  br_cond;
`ifdef KGP_EX_BRANCH_EN
    logic        out_br_taken;
`endif

    always #5 clk = ~clk;

    ex_stage #(.DATA_W(32), .RA_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .imm        (imm),
        .use_imm    (use_imm),
        .alu_signal (alu_signal),
        .rd         (rd),
        .flag_we    (flag_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_flags  (out_flags),
`ifdef KGP_EX_BRANCH_EN
        .br_cond      (br_cond),
        .out_br_taken (out_br_taken),
`endif
        .flags_q    (flags_q)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic [2:0]  fl;
        logic        br;
    } exp_t;

    exp_t       sb[$];
    int         n_checks  = 0;
    int         n_errors  = 0;
    int         n_drained = 0;
    logic [2:0] exp_fq    = 3'b000;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model, written from the operation definitions
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b_rt,
                                   input logic [31:0] b_imm, input logic ui,
                                   input logic [3:0] op, input logic [4:0] d,
                                   input logic [2:0] cond);
        exp_t        e;
        logic [31:0] b;
        logic [31:0] r;
        logic        c;
        logic        z;
        logic        s;
        logic        t;
        b = ui ? b_imm : b_rt;
        c = 1'b0;
        r = 32'd0;
        case (op)
            4'b0001: {c, r} = {1'b0, a} + {1'b0, b};
            4'b0010: begin r = a - b; c = (a >= b); end
            4'b0011: r = a & b;
            4'b0100: r = a | b;
            4'b0101: r = a ^ b;
            default: r = 32'd0;
        endcase
        z = (r == 32'd0);
        s = r[31];
        case (cond)
            3'b000: t = 1'b0;
            3'b001: t = 1'b1;
            3'b010: t = z;
            3'b011: t = !z;
            3'b100: t = s;
            3'b101: t = !s && !z;
            3'b110: t = c;
            default: t = !c;
        endcase
        e.res = r;
        e.rd  = d;
        e.fl  = {c, z, s};
        e.br  = t;
        return e;
    endfunction

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            check("flags_q", {61'd0, flags_q}, {61'd0, exp_fq});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_result", {32'd0, out_result}, {32'd0, e.res});
                    check("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
                    check("out_flags", {61'd0, out_flags}, {61'd0, e.fl});
`ifdef KGP_EX_BRANCH_EN
                    check("out_br_taken", {63'd0, out_br_taken}, {63'd0, e.br});
`endif
                    n_drained++;
                end
            end
            if (in_valid && in_ready) begin
                e = model(rs_val, rt_val, imm, use_imm, alu_signal, rd, br_cond);
                sb.push_back(e);
                if (flag_we) exp_fq = e.fl;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic ui, input logic [3:0] op, input logic [4:0] d,
                         input logic fwe, input logic [2:0] bc);
        in_valid   = 1'b1;
        rs_val     = a;
        rt_val     = b;
        imm        = im;
        use_imm    = ui;
        alu_signal = op;
        rd         = d;
        flag_we    = fwe;
        br_cond    = bc;
    endtask

    task automatic drain_all(input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        tick();
        check(tag, {32'd0, sb.size()}, 64'd0);
        check({tag, "_empty"}, {63'd0, out_valid}, 64'd0);
    endtask

    int          d0;
    logic [31:0] ra, rb;
    logic [3:0]  ops [5];

    initial begin
        ops[0] = ALU_ADD; ops[1] = ALU_SUB; ops[2] = ALU_AND;
        ops[3] = ALU_OR;  ops[4] = ALU_XOR;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        rs_val = '0; rt_val = '0; imm = '0; use_imm = 1'b0;
        alu_signal = '0; rd = '0; flag_we = 1'b0; br_cond = '0;
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_result", {32'd0, out_result}, 64'd0);
        check("rst_out_rd", {59'd0, out_rd}, 64'd0);
        check("rst_out_flags", {61'd0, out_flags}, 64'd0);
        check("rst_flags_q", {61'd0, flags_q}, 64'd0);
`ifdef KGP_EX_BRANCH_EN
        check("rst_br_taken", {63'd0, out_br_taken}, 64'd0);
`endif
        tick();
        rst = 1'b0;

        // -1 + 1 with flag update, then same op with br_cond = !Z
        out_ready = 1'b1;
        offer(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, ALU_ADD, 5'd3, 1'b1, BR_Z);
        tick();
        check("add_valid", {63'd0, out_valid}, 64'd1);
        check("add_result", {32'd0, out_result}, 64'd0);
        check("add_rd", {59'd0, out_rd}, 64'd3);
        check("add_flags", {61'd0, out_flags}, 64'h6);
        check("add_flags_q", {61'd0, flags_q}, 64'h6);
`ifdef KGP_EX_BRANCH_EN
        check("br_z_taken", {63'd0, out_br_taken}, 64'd1);
`endif
        offer(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, ALU_ADD, 5'd4, 1'b1, BR_NZ);
        tick();
        in_valid = 1'b0;
        check("add2_rd", {59'd0, out_rd}, 64'd4);
`ifdef KGP_EX_BRANCH_EN
        check("br_nz_taken", {63'd0, out_br_taken}, 64'd0);
`endif
        tick();
        check("add_drained", {63'd0, out_valid}, 64'd0);

        // Immediate operand, flags held
        offer(32'd7, 32'd100, 32'd5, 1'b1, ALU_ADD, 5'd9, 1'b0, BR_NEVER);
        tick();
        in_valid = 1'b0;
        check("imm_result", {32'd0, out_result}, 64'd12);
        check("imm_flags_q", {61'd0, flags_q}, 64'h6);
        tick();

        // Backpressure: three offers, two accepted
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(32'd10 + i, 32'd3, 32'd0, 1'b0, ops[i+1], 5'd5 + i[4:0], 1'b1, BR_S);
            tick();
        end
        in_valid = 1'b0;
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        check("bp_depth", {32'd0, sb.size()}, 64'd2);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bp_stable_res", {32'd0, out_result}, {32'd0, sb[0].res});
            check("bp_stable_rd", {59'd0, out_rd}, {59'd0, sb[0].rd});
        end
        drain_all("bp_drain");

        // Simultaneous accept and drain while holding one entry
        out_ready = 1'b0;
        offer(32'd1, 32'd2, 32'd0, 1'b0, ALU_ADD, 5'd1, 1'b0, BR_ALWAYS);
        tick();
        out_ready = 1'b1;
        d0 = n_drained;
        for (int i = 0; i < 4; i++) begin
            offer(32'd20 * i, 32'd7, 32'd0, 1'b0, ops[i], 5'd10 + i[4:0], 1'b1, BR_GT);
            tick();
            check("sim_out_valid", {63'd0, out_valid}, 64'd1);
            check("sim_in_ready", {63'd0, in_ready}, 64'd1);
        end
        check("sim_rate", {32'd0, n_drained - d0}, 64'd4);
        drain_all("sim_drain");

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            ra = $urandom();
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom();
            offer(ra, rb, $urandom(), 1'($urandom_range(0, 1)), ops[$urandom_range(0, 4)],
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain_all("rnd_drain");

        // Asynchronous reset while full
        out_ready = 1'b0;
        offer(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, ALU_ADD, 5'd2, 1'b1, BR_C);
        tick();
        offer(32'd3, 32'd4, 32'd0, 1'b0, ALU_ADD, 5'd6, 1'b1, BR_C);
        tick();
        in_valid = 1'b0;
        check("two_in_ready", {63'd0, in_ready}, 64'd0);
        #1 rst = 1'b1;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_flags_q", {61'd0, flags_q}, 64'd0);
        check("arst_out_result", {32'd0, out_result}, 64'd0);
        sb.delete();
        exp_fq = 3'b000;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_valid", {63'd0, out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
